// File: rtl/can_bit_timing.sv
// CAN bit-timing controller: divides the clock into time quanta, tracks SYNC/SEG1/SEG2,
// hard- or re-synchronises on recessive->dominant edges and issues the sample point.
module can_bit_timing #(
    parameter int BRP   = 2,
    parameter int TSEG1 = 5,
    parameter int TSEG2 = 2,
    parameter int SJW   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    input  logic       HS_EN,
    output logic       SP,
    output logic       RX_BIT,
    output logic       TQ,
    output logic       HSYNC,
    output logic       RSYNC,
    output logic [1:0] bit_state
);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_SEG1 = 2'd1,
        ST_SEG2 = 2'd2
    } state_t;

    localparam logic [7:0] BRP_LAST  = 8'(BRP - 1);
    localparam logic [4:0] TSEG1_LEN = 5'(TSEG1);
    localparam logic [4:0] TSEG2_LEN = 5'(TSEG2);
    localparam logic [4:0] SJW_LEN   = 5'(SJW);
    // The edge clock is the first clock of the new SYNC quantum, so a restart skips
    // prescaler value 0; with one-clock quanta that clock is the whole SYNC segment.
    localparam state_t     RESTART_STATE = (BRP == 1) ? ST_SEG1 : ST_SYNC;
    localparam logic [7:0] RESTART_PRESC = (BRP == 1) ? 8'd0 : 8'd1;

    state_t     state;
    logic [7:0] prescaler;
    logic [4:0] seg_cnt;
    logic [4:0] seg1_len;
    logic [4:0] seg2_len;
    logic       sync_ok;
    logic       r1, r2, r3;

    logic       tick;
    logic       sync_edge;
    logic       hard_sync;
    logic       late_adj;
    logic       early_restart;
    logic       early_shrink;
    logic [4:0] late_err;
    logic [4:0] late_step;
    logic [4:0] early_rem;
    logic [4:0] seg1_eff;
    logic [4:0] seg2_eff;

    always_comb begin
        tick          = (prescaler == BRP_LAST);
        sync_edge     = r3 & ~r2 & sync_ok;
        hard_sync     = sync_edge & HS_EN;
        late_err      = seg_cnt + 5'd1;
        late_step     = (late_err < SJW_LEN) ? late_err : SJW_LEN;
        early_rem     = seg2_len - seg_cnt;
        late_adj      = sync_edge & ~HS_EN & (state == ST_SEG1);
        early_restart = sync_edge & ~HS_EN & (state == ST_SEG2) & (early_rem <= SJW_LEN);
        early_shrink  = sync_edge & ~HS_EN & (state == ST_SEG2) & (early_rem > SJW_LEN);
        // Segment lengths as adjusted by this clock's edge, used by this clock's compare.
        seg1_eff      = late_adj ? (seg1_len + late_step) : seg1_len;
        seg2_eff      = early_shrink ? (seg2_len - SJW_LEN) : seg2_len;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_SYNC;
            prescaler <= '0;
            seg_cnt   <= '0;
            seg1_len  <= TSEG1_LEN;
            seg2_len  <= TSEG2_LEN;
            sync_ok   <= 1'b1;
            r1        <= 1'b1;
            r2        <= 1'b1;
            r3        <= 1'b1;
            SP        <= 1'b0;
            RX_BIT    <= 1'b1;
            TQ        <= 1'b0;
            HSYNC     <= 1'b0;
            RSYNC     <= 1'b0;
        end else begin
            r1        <= RX;
            r2        <= r1;
            r3        <= r2;
            SP        <= 1'b0;
            HSYNC     <= 1'b0;
            RSYNC     <= 1'b0;
            TQ        <= tick;
            prescaler <= tick ? 8'd0 : prescaler + 8'd1;

            if (hard_sync || early_restart) begin
                state     <= RESTART_STATE;
                prescaler <= RESTART_PRESC;
                seg_cnt   <= '0;
                seg1_len  <= TSEG1_LEN;
                seg2_len  <= TSEG2_LEN;
                sync_ok   <= 1'b0;
                HSYNC     <= hard_sync;
                RSYNC     <= early_restart;
            end else begin
                case (state)
                    ST_SYNC: begin
                        if (tick) begin
                            state   <= ST_SEG1;
                            seg_cnt <= '0;
                        end
                    end
                    ST_SEG1: begin
                        seg1_len <= seg1_eff;
                        if (late_adj) begin
                            RSYNC   <= 1'b1;
                            sync_ok <= 1'b0;
                        end
                        if (tick) begin
                            if (seg_cnt == seg1_eff - 5'd1) begin
                                SP      <= 1'b1;
                                RX_BIT  <= r2;
                                sync_ok <= 1'b1;
                                state   <= ST_SEG2;
                                seg_cnt <= '0;
                            end else begin
                                seg_cnt <= seg_cnt + 5'd1;
                            end
                        end
                    end
                    ST_SEG2: begin
                        seg2_len <= seg2_eff;
                        if (early_shrink) begin
                            RSYNC   <= 1'b1;
                            sync_ok <= 1'b0;
                        end
                        if (tick) begin
                            if (seg_cnt == seg2_eff - 5'd1) begin
                                state    <= ST_SYNC;
                                seg_cnt  <= '0;
                                seg1_len <= TSEG1_LEN;
                                seg2_len <= TSEG2_LEN;
                            end else begin
                                seg_cnt <= seg_cnt + 5'd1;
                            end
                        end
                    end
                    default: state <= ST_SYNC;
                endcase
            end
        end
    end

    assign bit_state = state;

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: table of RX edge scenarios with expected SP/sync events kept
// in scoreboard queues, plus a hand sequence for a reset pulse in the middle of SEG1.
module tb_can_bit_timing;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       RX    = 1'b1;
    logic       HS_EN = 1'b0;
    logic       SP, RX_BIT, TQ, HSYNC, RSYNC;
    logic [1:0] bit_state;

    can_bit_timing #(.BRP(2), .TSEG1(5), .TSEG2(2), .SJW(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .RX        (RX),
        .HS_EN     (HS_EN),
        .SP        (SP),
        .RX_BIT    (RX_BIT),
        .TQ        (TQ),
        .HSYNC     (HSYNC),
        .RSYNC     (RSYNC),
        .bit_state (bit_state)
    );

    always #5 clock = ~clock;

    // Cycle c = number of rising edges since the last edge that sampled reset high.
    // fall/rise = cycle whose edge first samples the new RX value (0 = unused).
    // sync_kind: 2'b10 HSYNC, 2'b01 RSYNC, 2'b00 none.
    typedef struct {
        bit         hs_en;
        int         fall1;
        int         rise;
        int         fall2;
        logic [1:0] sync_kind;
        int         sync_cyc;
        int         sp0, sp1, sp2;
        logic       b0, b1, b2;
        bit         chk_tq;
    } vec_t;

    vec_t        vecs[9];
    logic [16:0] exp_q[$];
    logic [17:0] ev_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_cycle(input int c);
        logic [16:0] e_sp;
        logic [17:0] e_ev;
        if (SP === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sp_unexpected: SP at cycle %0d bit %0b, none required", c, RX_BIT);
            end else begin
                e_sp = exp_q.pop_front();
                if (e_sp !== {RX_BIT, 16'(c)}) begin
                    n_fail++;
                    $display("FAIL sp_event: got cycle %0d bit %0b, required cycle %0d bit %0b",
                             c, RX_BIT, e_sp[15:0], e_sp[16]);
                end
            end
        end
        if (HSYNC !== 1'b0 || RSYNC !== 1'b0) begin
            n_checks++;
            if (ev_q.size() == 0) begin
                n_fail++;
                $display("FAIL sync_unexpected: hsync=%0b rsync=%0b at cycle %0d, none required",
                         HSYNC, RSYNC, c);
            end else begin
                e_ev = ev_q.pop_front();
                if (e_ev !== {HSYNC, RSYNC, 16'(c)}) begin
                    n_fail++;
                    $display("FAIL sync_event: got hs/rs=%b%b at cycle %0d, required %b at cycle %0d",
                             HSYNC, RSYNC, c, e_ev[17:16], e_ev[15:0]);
                end
            end
        end
    endtask

    task automatic drain();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sp_missing: %0d pending, next required at cycle %0d",
                     exp_q.size(), exp_q[0][15:0]);
        end
        exp_q.delete();
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL sync_missing: %0d pending, next required %b at cycle %0d",
                     ev_q.size(), ev_q[0][17:16], ev_q[0][15:0]);
        end
        ev_q.delete();
    endtask

    task automatic check_reset_state();
        n_checks++;
        if ({SP, RX_BIT, TQ, HSYNC, RSYNC, bit_state} !== 7'b0100000) begin
            n_fail++;
            $display("FAIL reset_state: got sp/bit/tq/hs/rs/state=%b, required 0100000",
                     {SP, RX_BIT, TQ, HSYNC, RSYNC, bit_state});
        end
    endtask

    // Leaves the bench at the falling edge of cycle 0.
    task automatic do_reset(input bit hs);
        @(negedge clock);
        reset = 1'b1;
        RX    = 1'b1;
        HS_EN = hs;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        int   last;
        logic exp_tq;
        do_reset(v.hs_en);
        check_reset_state();
        exp_q.push_back({v.b0, 16'(v.sp0)});
        exp_q.push_back({v.b1, 16'(v.sp1)});
        exp_q.push_back({v.b2, 16'(v.sp2)});
        if (v.sync_kind != 2'b00) ev_q.push_back({v.sync_kind, 16'(v.sync_cyc)});
        last = v.sp2 + 2;
        for (int c = 0; c <= last; c++) begin
            check_cycle(c);
            if (v.chk_tq) begin
                exp_tq = (c > 0) && (c % 2 == 0);
                n_checks++;
                if (TQ !== exp_tq) begin
                    n_fail++;
                    $display("FAIL tq_pulse: cycle %0d got %b, required %b", c, TQ, exp_tq);
                end
            end
            if (c + 1 == v.fall1 || c + 1 == v.fall2) RX = 1'b0;
            if (c + 1 == v.rise) RX = 1'b1;
            @(negedge clock);
        end
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            hs fall1 rise fall2 kind    cyc sp0 sp1 sp2 b0 b1 b2 tq
        vecs[0] = '{1'b0,  0,  0,  0, 2'b00,  0, 12, 28, 44, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b1,  7,  0,  0, 2'b10,  9, 20, 36, 52, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 26,  0,  0, 2'b10, 28, 12, 39, 55, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 19,  0,  0, 2'b01, 21, 12, 30, 46, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 26,  0,  0, 2'b01, 28, 12, 30, 46, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 27,  0,  0, 2'b01, 29, 12, 28, 42, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 29,  0,  0, 2'b01, 31, 12, 28, 42, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 30,  0,  0, 2'b01, 32, 12, 28, 43, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 19, 22, 24, 2'b01, 21, 12, 30, 46, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) run_row(vecs[i]);

        // Late resync, RX back to recessive, then a one-clock reset pulse inside SEG1.
        do_reset(1'b0);
        check_reset_state();
        exp_q.push_back({1'b1, 16'd12});
        exp_q.push_back({1'b0, 16'd30});
        ev_q.push_back({2'b01, 16'd21});
        for (int c = 0; c <= 38; c++) begin
            check_cycle(c);
            if (c == 18) RX = 1'b0;
            if (c == 35) RX = 1'b1;
            if (c == 38) reset = 1'b1;
            @(negedge clock);
        end
        drain();
        reset = 1'b0;
        check_reset_state();
        exp_q.push_back({1'b1, 16'd12});
        for (int c = 0; c <= 14; c++) begin
            check_cycle(c);
            @(negedge clock);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
